// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, handles hazard stalls, multicycle
// memory waits, downstream redirects, HALT detection and sticky fetch errors.
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirectPC,
    input  logic [15:0] imemData,
    input  logic        imemStall,
    input  logic        imemDone,
    input  logic        imemErr,
    output logic [15:0] imemAddr,
    output logic        imemRd,
    output logic [15:0] instructionF,
    output logic [15:0] incPCF,
    output logic        branchInstF,
    output logic        errF,
    output logic        haltF
);

    localparam int unsigned PC_W    = 16;
    localparam logic [PC_W-1:0] NOP_WORD = 16'h0800;
    localparam logic [PC_W-1:0] PC_STEP  = 16'd2;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] tgt_q, tgt_d;
    logic            pend_q, pend_d;
    logic            err_q, err_d;
    logic            deliver_c;
    logic            is_halt_c;

    assign is_halt_c = (imemData[15:11] == 5'b00000);

    // State register; reset discards any pending wait or redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            tgt_q   <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; redirect always wins over stall, memory wait and halt.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        pend_d    = pend_q;
        err_d     = err_q;
        deliver_c = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (redirect) begin
                    pc_d = redirectPC;
                end else if (imemStall) begin
                    state_d = S_WAIT;
                end else begin
                    deliver_c = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect && imemDone) begin
                    pc_d    = redirectPC;
                    pend_d  = 1'b0;
                    state_d = S_RUN;
                end else if (redirect) begin
                    // Access still outstanding: remember the newest target only.
                    tgt_d  = redirectPC;
                    pend_d = 1'b1;
                end else if (imemDone) begin
                    state_d = S_RUN;
                    if (pend_q) begin
                        pc_d   = tgt_q;
                        pend_d = 1'b0;
                    end else begin
                        deliver_c = 1'b1;
                    end
                end
            end
            S_HALTED: begin
                if (redirect) begin
                    pc_d    = redirectPC;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        // A stalled HALT is re-presented and only takes effect once accepted.
        if (deliver_c) begin
            if (pc_q[0] || imemErr) begin
                err_d = 1'b1;
            end
            if (!stall) begin
                if (is_halt_c) begin
                    state_d = S_HALTED;
                end else begin
                    pc_d = pc_q + PC_STEP;
                end
            end
        end
    end

    assign imemAddr     = pc_q;
    assign imemRd       = rst && (state_q != S_HALTED);
    assign incPCF       = pc_q + PC_STEP;
    assign instructionF = (rst && deliver_c) ? imemData : NOP_WORD;
    assign branchInstF  = (instructionF[15:13] == 3'b011) || (instructionF[15:13] == 3'b001);
    assign errF         = err_q;
    assign haltF        = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, each cycle
// compared against a behavioural fetch model driven by a bench-side memory.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_data;
    logic        imem_stall;
    logic        imem_done;
    logic        imem_err;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] instruction_f;
    logic [15:0] inc_pc_f;
    logic        branch_inst_f;
    logic        err_f;
    logic        halt_f;

    fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirectPC   (redirect_pc),
        .imemData     (imem_data),
        .imemStall    (imem_stall),
        .imemDone     (imem_done),
        .imemErr      (imem_err),
        .imemAddr     (imem_addr),
        .imemRd       (imem_rd),
        .instructionF (instruction_f),
        .incPCF       (inc_pc_f),
        .branchInstF  (branch_inst_f),
        .errF         (err_f),
        .haltF        (halt_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];

    int n_assert = 0;
    int n_fail   = 0;

    // Model of the fetch unit: where it fetches from and what is outstanding.
    logic [15:0] m_pc;
    logic [15:0] m_tgt;
    logic        m_waiting;
    logic        m_halted;
    logic        m_pending;
    logic        m_err;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = 16'h0000;
        m_tgt     = 16'h0000;
        m_waiting = 1'b0;
        m_halted  = 1'b0;
        m_pending = 1'b0;
        m_err     = 1'b0;
    endtask

    // Called at posedge+1: asserts reset, checks reset outputs, releases at next posedge+1.
    task automatic do_reset();
        rst        = 1'b0;
        stall      = 1'b0;
        redirect   = 1'b0;
        imem_stall = 1'b0;
        imem_done  = 1'b0;
        imem_err   = 1'b0;
        #1;
        chk("rst_instr",  instruction_f, 16'h0800);
        chk("rst_branch", 16'(branch_inst_f), 16'h0000);
        chk("rst_rd",     16'(imem_rd), 16'h0000);
        chk("rst_incpc",  inc_pc_f, 16'h0002);
        chk("rst_addr",   imem_addr, 16'h0000);
        chk("rst_err",    16'(err_f), 16'h0000);
        chk("rst_halt",   16'(halt_f), 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic step(input logic st, input logic rd, input logic [15:0] rpc,
                        input logic ims, input logic dn, input logic er);
        logic [15:0] w, e_instr, n_pc, n_tgt;
        logic        dlv, e_br, n_waiting, n_halted, n_pending, n_err;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_stall  = ims;
        imem_done   = dn;
        imem_err    = er;
        imem_data   = mem[imem_addr];

        w         = mem[m_pc];
        dlv       = 1'b0;
        n_pc      = m_pc;
        n_tgt     = m_tgt;
        n_waiting = m_waiting;
        n_halted  = m_halted;
        n_pending = m_pending;
        n_err     = m_err;

        if (m_halted) begin
            if (rd) begin
                n_pc     = rpc;
                n_halted = 1'b0;
            end
        end else if (m_waiting) begin
            if (rd && dn) begin
                n_pc      = rpc;
                n_pending = 1'b0;
                n_waiting = 1'b0;
            end else if (rd) begin
                n_tgt     = rpc;
                n_pending = 1'b1;
            end else if (dn && m_pending) begin
                n_pc      = m_tgt;
                n_pending = 1'b0;
                n_waiting = 1'b0;
            end else if (dn) begin
                dlv       = 1'b1;
                n_waiting = 1'b0;
            end
        end else begin
            if (rd)       n_pc = rpc;
            else if (ims) n_waiting = 1'b1;
            else          dlv = 1'b1;
        end

        if (dlv) begin
            if (m_pc[0] || er) n_err = 1'b1;
            if (!st) begin
                if (w[15:11] == 5'b00000) n_halted = 1'b1;
                else                      n_pc = m_pc + 16'd2;
            end
        end
        e_instr = dlv ? w : 16'h0800;
        e_br    = dlv && ((w[15:13] == 3'b011) || (w[15:13] == 3'b001));

        #3;
        chk("addr",   imem_addr, m_pc);
        chk("rd",     16'(imem_rd), 16'(!m_halted));
        chk("instr",  instruction_f, e_instr);
        chk("incpc",  inc_pc_f, m_pc + 16'd2);
        chk("branch", 16'(branch_inst_f), 16'(e_br));
        chk("err",    16'(err_f), 16'(m_err));
        chk("halt",   16'(halt_f), 16'(m_halted));

        m_pc      = n_pc;
        m_tgt     = n_tgt;
        m_waiting = n_waiting;
        m_halted  = n_halted;
        m_pending = n_pending;
        m_err     = n_err;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic jump(input logic [15:0] target);
        step(1'b0, 1'b1, target, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic        st, rd, ims, dn, er;
        logic [15:0] rpc;

        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        imem_data = 16'h0000; imem_stall = 1'b0; imem_done = 1'b0; imem_err = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0000] = 16'h4000;
        mem[16'h0002] = 16'h4100;
        mem[16'h0004] = 16'h4200;
        mem[16'h0006] = 16'h4300;
        mem[16'h0010] = 16'h4400;
        mem[16'h0200] = 16'h4500;
        mem[16'h0020] = 16'h0000;
        mem[16'h0030] = 16'h6123;
        mem[16'h0032] = 16'h2abc;
        mem[16'h0034] = 16'h4600;
        mem[16'h0031] = 16'h4700;
        mem[16'h0033] = 16'h4800;
        mem[16'hFFFE] = 16'h4900;
        model_reset();
        #1;
        do_reset();

        // Two sequential fetches from reset.
        idle();
        idle();
        // Hazard stall for two cycles at 0x0004.
        chk("stall_addr0", imem_addr, 16'h0004);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        idle();
        chk("stall_after", imem_addr, 16'h0006);
        // Redirect beats stall.
        step(1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        chk("redir_addr", imem_addr, 16'h0100);
        // Memory wait with redirect latched mid-wait.
        jump(16'h0010);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0200, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        chk("wait_redir_addr", imem_addr, 16'h0200);
        idle();
        // Plain memory wait delivering its word.
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        // HALT, then escape via redirect.
        jump(16'h0020);
        idle();
        chk("halt_flag", 16'(halt_f), 16'h0001);
        idle();
        idle();
        jump(16'h0030);
        chk("halt_exit_addr", imem_addr, 16'h0030);
        idle();
        idle();
        idle();
        // Misaligned fetch sets the sticky error.
        jump(16'h0031);
        idle();
        chk("err_set", 16'(err_f), 16'h0001);
        idle();
        // PC wrap.
        jump(16'hFFFE);
        idle();
        chk("wrap_addr", imem_addr, 16'h0000);
        do_reset();
        // Reset mid-wait with a latched redirect.
        idle();
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0300, 1'b1, 1'b0, 1'b0);
        do_reset();
        idle();
        idle();

        // Random traffic with periodic resets.
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 499) begin
                do_reset();
            end
            st  = ($urandom_range(0, 4) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = 16'($urandom);
            if ($urandom_range(0, 15) != 0) rpc[0] = 1'b0;
            ims = ($urandom_range(0, 5) == 0);
            dn  = ($urandom_range(0, 2) == 0);
            er  = ($urandom_range(0, 49) == 0);
            step(st, rd, rpc, ims, dn, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
